// File: rtl/pong_game_gen.sv
// Two-player pong engine and pixel generator: paddles, ball, scoring, serve/miss/over FSM, net.
// State updates once per frame on the refresh tick (serve acts on any cycle); rgb is combinational from registers and x/y.
module pong_game_gen #(
  parameter int TABLE_WIDTH     = 640,
  parameter int TABLE_HEIGHT    = 480,
  parameter int X_BIT_WIDTH     = 10,
  parameter int Y_BIT_WIDTH     = 10,
  parameter int PADDLE_HEIGHT   = 120,
  parameter int PADDLE_WIDTH    = 4,
  parameter int PADDLE_VELOCITY = 4,
  parameter int BALL_SPEED      = 2,
  parameter int BALL_SIZE       = 8,
  parameter int SCORE_MAX       = 9,
  parameter int MISS_FRAMES     = 60,
  parameter int RGB_WIDTH       = 1,
  parameter int PAD_COLOR       = 1,
  parameter int BALL_COLOR      = 1,
  parameter int NET_COLOR       = 1,
  parameter int BG_COLOR        = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   up_l,
  input  logic                   down_l,
  input  logic                   up_r,
  input  logic                   down_r,
  input  logic                   serve,
  input  logic                   video_on,
  input  logic [X_BIT_WIDTH-1:0] x,
  input  logic [Y_BIT_WIDTH-1:0] y,
  output logic [RGB_WIDTH-1:0]   rgb,
  output logic [3:0]             score_l,
  output logic [3:0]             score_r,
  output logic                   game_over
);

  typedef logic signed [X_BIT_WIDTH:0] sx_t;
  typedef logic signed [Y_BIT_WIDTH:0] sy_t;
  typedef logic [X_BIT_WIDTH-1:0]      ux_t;
  typedef logic [Y_BIT_WIDTH-1:0]      uy_t;
  typedef enum logic [1:0] {IDLE, PLAY, MISS, OVER} state_t;

  localparam int OFF     = TABLE_WIDTH / 20;
  localparam int PAD_MAX = TABLE_HEIGHT - PADDLE_HEIGHT;
  localparam int X_MAX   = TABLE_WIDTH - BALL_SIZE;
  localparam int Y_MAX   = TABLE_HEIGHT - BALL_SIZE;
  localparam int CNT_W   = $clog2(MISS_FRAMES + 1);

  localparam sx_t SPD_X     = sx_t'(BALL_SPEED);
  localparam sy_t SPD_Y     = sy_t'(BALL_SPEED);
  localparam sx_t SX_ZERO   = sx_t'(0);
  localparam sy_t SY_ZERO   = sy_t'(0);
  localparam sx_t X_MAX_S   = sx_t'(X_MAX);
  localparam sy_t Y_MAX_S   = sy_t'(Y_MAX);
  localparam sx_t LHIT_NX   = sx_t'(OFF + PADDLE_WIDTH - 1);
  localparam sx_t RHIT_NX   = sx_t'(TABLE_WIDTH - OFF - PADDLE_WIDTH - BALL_SIZE + 1);
  localparam ux_t LHIT_X    = ux_t'(OFF);
  localparam ux_t RHIT_X    = ux_t'(TABLE_WIDTH - OFF - BALL_SIZE);
  localparam ux_t LBOUNCE_X = ux_t'(OFF + PADDLE_WIDTH);
  localparam ux_t RBOUNCE_X = ux_t'(TABLE_WIDTH - OFF - PADDLE_WIDTH - BALL_SIZE);
  localparam ux_t BALL_X0   = ux_t'(X_MAX / 2);
  localparam uy_t BALL_Y0   = uy_t'(Y_MAX / 2);
  localparam uy_t Y_MAX_U   = uy_t'(Y_MAX);
  localparam uy_t PAD_Y0    = uy_t'(PAD_MAX / 2);
  localparam uy_t PAD_MAX_Y = uy_t'(PAD_MAX);
  localparam uy_t PAD_VEL   = uy_t'(PADDLE_VELOCITY);
  localparam uy_t PAD_LAST  = uy_t'(PADDLE_HEIGHT - 1);
  localparam ux_t LP_L_X    = ux_t'(OFF);
  localparam ux_t LP_R_X    = ux_t'(OFF + PADDLE_WIDTH - 1);
  localparam ux_t RP_L_X    = ux_t'(TABLE_WIDTH - OFF - PADDLE_WIDTH);
  localparam ux_t RP_R_X    = ux_t'(TABLE_WIDTH - OFF - 1);
  localparam ux_t NET_L_X   = ux_t'(TABLE_WIDTH / 2 - 1);
  localparam ux_t NET_R_X   = ux_t'(TABLE_WIDTH / 2);
  localparam ux_t BALL_LX   = ux_t'(BALL_SIZE - 1);
  localparam uy_t BALL_LY   = uy_t'(BALL_SIZE - 1);
  localparam uy_t TICK_Y    = uy_t'(TABLE_HEIGHT + 1);
  localparam logic [3:0]       SCORE_LIM = 4'(SCORE_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MISS_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       score_l_q, score_l_d, score_r_q, score_r_d;
  uy_t              pad_l_q, pad_l_d, pad_r_q, pad_r_d;
  ux_t              ball_x_q, ball_x_d;
  uy_t              ball_y_q, ball_y_d;
  logic             dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic             dx_serve_neg_q, dx_serve_neg_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             game_over_q, game_over_d;

  logic tick, point, l_overlap, r_overlap;
  sx_t  nx;
  sy_t  ny;

  function automatic uy_t pad_step(uy_t top, logic up, logic dn);
    uy_t r;
    r = top;
    if (up)      r = (top >= PAD_VEL) ? top - PAD_VEL : '0;
    else if (dn) r = (top <= PAD_MAX_Y - PAD_VEL) ? top + PAD_VEL : PAD_MAX_Y;
    return r;
  endfunction

  function automatic logic [7:0] ball_row(logic [2:0] r);
    case (r)
      3'd0, 3'd7: return 8'h3C;
      3'd1, 3'd6: return 8'h7E;
      default:    return 8'hFF;
    endcase
  endfunction

  assign tick      = (y == TICK_Y) && (x == '0);
  assign nx        = sx_t'({1'b0, ball_x_q}) + (dx_neg_q ? -SPD_X : SPD_X);
  assign ny        = sy_t'({1'b0, ball_y_q}) + (dy_neg_q ? -SPD_Y : SPD_Y);
  assign l_overlap = (ball_y_q <= pad_l_q + PAD_LAST) && (ball_y_q + BALL_LY >= pad_l_q);
  assign r_overlap = (ball_y_q <= pad_r_q + PAD_LAST) && (ball_y_q + BALL_LY >= pad_r_q);

  always_comb begin
    state_d        = state_q;
    score_l_d      = score_l_q;
    score_r_d      = score_r_q;
    pad_l_d        = pad_l_q;
    pad_r_d        = pad_r_q;
    ball_x_d       = ball_x_q;
    ball_y_d       = ball_y_q;
    dx_neg_d       = dx_neg_q;
    dy_neg_d       = dy_neg_q;
    dx_serve_neg_d = dx_serve_neg_q;
    miss_cnt_d     = miss_cnt_q;
    point          = 1'b0;

    if (tick && state_q != OVER) begin
      pad_l_d = pad_step(pad_l_q, up_l, down_l);
      pad_r_d = pad_step(pad_r_q, up_r, down_r);
    end

    case (state_q)
      IDLE: if (serve) state_d = PLAY;
      PLAY: if (tick) begin
        if (ny <= SY_ZERO) begin
          ball_y_d = '0;
          dy_neg_d = 1'b0;
        end else if (ny >= Y_MAX_S) begin
          ball_y_d = Y_MAX_U;
          dy_neg_d = 1'b1;
        end else begin
          ball_y_d = ny[Y_BIT_WIDTH-1:0];
        end
        // Paddle hits are only taken when the ball is still in front of the paddle face.
        if (dx_neg_q && nx <= LHIT_NX && ball_x_q >= LHIT_X && l_overlap) begin
          ball_x_d = LBOUNCE_X;
          dx_neg_d = 1'b0;
        end else if (!dx_neg_q && nx >= RHIT_NX && ball_x_q <= RHIT_X && r_overlap) begin
          ball_x_d = RBOUNCE_X;
          dx_neg_d = 1'b1;
        end else if (nx < SX_ZERO) begin
          score_r_d      = score_r_q + 4'd1;
          dx_serve_neg_d = 1'b1;
          point          = 1'b1;
        end else if (nx > X_MAX_S) begin
          score_l_d      = score_l_q + 4'd1;
          dx_serve_neg_d = 1'b0;
          point          = 1'b1;
        end else begin
          ball_x_d = nx[X_BIT_WIDTH-1:0];
        end
        if (point) begin
          ball_x_d   = BALL_X0;
          ball_y_d   = BALL_Y0;
          miss_cnt_d = '0;
          state_d    = (score_l_d == SCORE_LIM || score_r_d == SCORE_LIM) ? OVER : MISS;
        end
      end
      MISS: if (tick) begin
        if (miss_cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          dx_neg_d = dx_serve_neg_q;
          dy_neg_d = 1'b0;
        end else begin
          miss_cnt_d = miss_cnt_q + CNT_ONE;
        end
      end
      OVER: if (serve) begin
        score_l_d = '0;
        score_r_d = '0;
        state_d   = IDLE;
        dx_neg_d  = dx_serve_neg_q;
        dy_neg_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      score_l_q      <= '0;
      score_r_q      <= '0;
      pad_l_q        <= PAD_Y0;
      pad_r_q        <= PAD_Y0;
      ball_x_q       <= BALL_X0;
      ball_y_q       <= BALL_Y0;
      dx_neg_q       <= 1'b0;
      dy_neg_q       <= 1'b0;
      dx_serve_neg_q <= 1'b0;
      miss_cnt_q     <= '0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      score_l_q      <= score_l_d;
      score_r_q      <= score_r_d;
      pad_l_q        <= pad_l_d;
      pad_r_q        <= pad_r_d;
      ball_x_q       <= ball_x_d;
      ball_y_q       <= ball_y_d;
      dx_neg_q       <= dx_neg_d;
      dy_neg_q       <= dy_neg_d;
      dx_serve_neg_q <= dx_serve_neg_d;
      miss_cnt_q     <= miss_cnt_d;
      game_over_q    <= game_over_d;
    end
  end

  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;

  logic [2:0] bm_row, bm_col;
  logic [7:0] bm_bits;
  logic       on_pad, on_ball, on_net;

  // The bitmap index wraps modulo 8, so the ball need not sit on an 8-pixel grid.
  assign bm_row  = y[2:0] - ball_y_q[2:0];
  assign bm_col  = x[2:0] - ball_x_q[2:0];
  assign bm_bits = ball_row(bm_row);
  assign on_pad  = (x >= LP_L_X && x <= LP_R_X && y >= pad_l_q && y <= pad_l_q + PAD_LAST) ||
                   (x >= RP_L_X && x <= RP_R_X && y >= pad_r_q && y <= pad_r_q + PAD_LAST);
  assign on_ball = (state_q != OVER) && x >= ball_x_q && x <= ball_x_q + BALL_LX &&
                   y >= ball_y_q && y <= ball_y_q + BALL_LY && bm_bits[3'd7 - bm_col];
  assign on_net  = (x == NET_L_X || x == NET_R_X) && !y[3];

  always_comb begin
    rgb = RGB_WIDTH'(BG_COLOR);
    if (!video_on)    rgb = '0;
    else if (on_pad)  rgb = RGB_WIDTH'(PAD_COLOR);
    else if (on_ball) rgb = RGB_WIDTH'(BALL_COLOR);
    else if (on_net)  rgb = RGB_WIDTH'(NET_COLOR);
  end

endmodule
